// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg
// Purpose: shared definitions for the Go Board display counter controller.
//          Holds the FSM state encoding, the BCD digit constants used by
//          the step arithmetic, the default 25 MHz timing values and a
//          helper that sizes the repeat timer.
// Ports:   none (package).
package count_ctrl_pkg;

    // Grant/repeat controller states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DELAY      = 2'd1,
        ST_REPEAT     = 2'd2,
        ST_CLEAR_HOLD = 2'd3
    } state_e;

    // BCD digit limits used by the step arithmetic.
    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;

    // Default timing for a 25 MHz board clock.
    localparam int DEFAULT_COUNT_LIMIT  = 99;
    localparam int DEFAULT_REPEAT_DELAY = 12_500_000;  // 0.5 s to first repeat
    localparam int DEFAULT_REPEAT_RATE  = 2_500_000;   // 10 Hz repeat

    // Width of one down-counter able to hold the larger of the two reload
    // values (each reload is the interval minus one).
    function automatic int timer_width(input int delay_cycles, input int rate_cycles);
        int biggest;
        biggest = (delay_cycles > rate_cycles) ? delay_cycles : rate_cycles;
        if (biggest < 2) begin
            return 1;
        end
        return $clog2(biggest);
    endfunction

endpackage

// File: rtl/count_ctrl_bcd_step.sv
// count_ctrl_bcd_step
// Purpose: combinational one-step BCD increment/decrement with wrap at a
//          programmable two-digit limit. Shared by the Up and Down paths.
// Ports:
//   tens_i, ones_i         current BCD value
//   up_i                   1 = increment, 0 = decrement
//   lim_tens_i, lim_ones_i BCD limit value (wrap point)
//   tens_o, ones_o         stepped BCD value
//   wrap_o                 1 when this step wrapped around the range
module count_ctrl_bcd_step
    import count_ctrl_pkg::*;
(
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic       up_i,
    input  logic [3:0] lim_tens_i,
    input  logic [3:0] lim_ones_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       wrap_o
);

    // Digit-wise arithmetic keeps the value in BCD so the display encoders
    // can consume each digit directly; no binary conversion is needed.
    always_comb begin
        tens_o = tens_i;
        ones_o = ones_i;
        wrap_o = 1'b0;
        if (up_i) begin
            if ((tens_i == lim_tens_i) && (ones_i == lim_ones_i)) begin
                tens_o = BCD_ZERO;
                ones_o = BCD_ZERO;
                wrap_o = 1'b1;
            end else if (ones_i == BCD_NINE) begin
                ones_o = BCD_ZERO;
                tens_o = tens_i + 4'd1;
            end else begin
                ones_o = ones_i + 4'd1;
            end
        end else begin
            if ((tens_i == BCD_ZERO) && (ones_i == BCD_ZERO)) begin
                tens_o = lim_tens_i;
                ones_o = lim_ones_i;
                wrap_o = 1'b1;
            end else if (ones_i == BCD_ZERO) begin
                ones_o = BCD_NINE;
                tens_o = tens_i - 4'd1;
            end else begin
                ones_o = ones_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl
// Purpose: sequences the two-digit BCD display counter from debounced
//          button levels. Edge-detects Clear/Up/Down, arbitrates them
//          (Clear > Up > Down), adds press-and-hold auto-repeat and owns
//          the count value.
// Parameters:
//   COUNT_LIMIT   maximum count (0..99), wrap point for Up and Down
//   REPEAT_DELAY  cycles from first step to first auto-repeat (>= 2)
//   REPEAT_RATE   cycles between auto-repeat steps (>= 2)
// Ports:
//   i_Clk     system clock
//   i_Rst_L   synchronous active-low reset
//   i_Clear   debounced clear request level
//   i_Up      debounced increment request level
//   i_Down    debounced decrement request level
//   o_Ones    BCD ones digit
//   o_Tens    BCD tens digit
//   o_Wrap    one-cycle pulse on a wrapping step
//   o_Active  high while a request holds the grant
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int COUNT_LIMIT  = DEFAULT_COUNT_LIMIT,
    parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Clear,
    input  logic       i_Up,
    input  logic       i_Down,
    output logic [3:0] o_Ones,
    output logic [3:0] o_Tens,
    output logic       o_Wrap,
    output logic       o_Active
);

    localparam int TIMER_W = timer_width(REPEAT_DELAY, REPEAT_RATE);

    // The timer is loaded with interval-1 on a step and the next step fires
    // when it reads zero, giving exactly one step per interval.
    localparam logic [TIMER_W-1:0] DELAY_RELOAD = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] RATE_RELOAD  = TIMER_W'(REPEAT_RATE - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO   = '0;
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    localparam logic [3:0] LIM_TENS = 4'(COUNT_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(COUNT_LIMIT % 10);

    state_e             state_q;
    logic [3:0]         tens_q;
    logic [3:0]         ones_q;
    logic               wrap_q;
    logic               dir_up_q;
    logic [TIMER_W-1:0] timer_q;
    logic               clear_prev_q;
    logic               up_prev_q;
    logic               down_prev_q;

    logic               clear_press;
    logic               up_press;
    logic               down_press;
    logic               step_up;
    logic               granted_level;
    logic [3:0]         tens_d;
    logic [3:0]         ones_d;
    logic               wrap_d;

    assign clear_press = i_Clear & ~clear_prev_q;
    assign up_press    = i_Up    & ~up_prev_q;
    assign down_press  = i_Down  & ~down_prev_q;

    // In IDLE the step direction comes from this cycle's winning press;
    // once granted it is locked to the stored direction.
    assign step_up       = (state_q == ST_IDLE) ? up_press : dir_up_q;
    assign granted_level = dir_up_q ? i_Up : i_Down;

    count_ctrl_bcd_step u_bcd_step (
        .tens_i     (tens_q),
        .ones_i     (ones_q),
        .up_i       (step_up),
        .lim_tens_i (LIM_TENS),
        .lim_ones_i (LIM_ONES),
        .tens_o     (tens_d),
        .ones_o     (ones_d),
        .wrap_o     (wrap_d)
    );

    // Single registered FSM. Previous-sample registers reset to 1 so that a
    // button held through reset must be released before it counts as a press.
    // Release takes precedence over a coinciding timer expiry; a Clear press
    // preempts an Up/Down grant.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q      <= ST_IDLE;
            tens_q       <= BCD_ZERO;
            ones_q       <= BCD_ZERO;
            wrap_q       <= 1'b0;
            dir_up_q     <= 1'b0;
            timer_q      <= TIMER_ZERO;
            clear_prev_q <= 1'b1;
            up_prev_q    <= 1'b1;
            down_prev_q  <= 1'b1;
        end else begin
            clear_prev_q <= i_Clear;
            up_prev_q    <= i_Up;
            down_prev_q  <= i_Down;
            wrap_q       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (clear_press) begin
                        tens_q  <= BCD_ZERO;
                        ones_q  <= BCD_ZERO;
                        state_q <= ST_CLEAR_HOLD;
                    end else if (up_press || down_press) begin
                        tens_q   <= tens_d;
                        ones_q   <= ones_d;
                        wrap_q   <= wrap_d;
                        dir_up_q <= up_press;
                        timer_q  <= DELAY_RELOAD;
                        state_q  <= ST_DELAY;
                    end
                end

                ST_DELAY, ST_REPEAT: begin
                    if (clear_press) begin
                        tens_q  <= BCD_ZERO;
                        ones_q  <= BCD_ZERO;
                        timer_q <= TIMER_ZERO;
                        state_q <= ST_CLEAR_HOLD;
                    end else if (!granted_level) begin
                        timer_q <= TIMER_ZERO;
                        state_q <= ST_IDLE;
                    end else if (timer_q == TIMER_ZERO) begin
                        tens_q  <= tens_d;
                        ones_q  <= ones_d;
                        wrap_q  <= wrap_d;
                        timer_q <= RATE_RELOAD;
                        state_q <= ST_REPEAT;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end

                ST_CLEAR_HOLD: begin
                    if (!i_Clear) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Tens   = tens_q;
    assign o_Ones   = ones_q;
    assign o_Wrap   = wrap_q;
    assign o_Active = (state_q != ST_IDLE);

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Controller that sequences the two-digit display counter on the Go Board from debounced push-button levels. It edge-detects three requesters (clear, up, down), arbitrates between them, adds press-and-hold auto-repeat, and owns the BCD count value. Its outputs feed two seven_segment encoders, tens on Segment1 and ones on Segment2. It sits between the debounce_module instances and the display encoders and replaces the ad-hoc counter in the top level.

## Interface
- COUNT_LIMIT, 99: maximum count (0..99); up from COUNT_LIMIT wraps to 0, down from 0 wraps to COUNT_LIMIT.
- REPEAT_DELAY, 12_500_000: cycles from first step to first auto-repeat step (0.5 s at 25 MHz); must be ≥2.
- REPEAT_RATE, 2_500_000: cycles between successive auto-repeat steps (10 Hz); must be ≥2.
- i_Clk  in  1  system clock; one clock for the whole block.
- i_Rst_L  in  1  synchronous, active-low reset, sampled on rising edge of i_Clk.
- i_Clear  in  1  debounced level, clear request.
- i_Up  in  1  debounced level, increment request.
- i_Down  in  1  debounced level, decrement request.
- o_Ones  out  4  BCD ones digit, 0..9.
- o_Tens  out  4  BCD tens digit, 0..9.
- o_Wrap  out  1  one-cycle pulse on any wrap step.
- o_Active  out  1  high while a request holds the grant (any state but IDLE).

## Operation
- Reset, with i_Rst_L = 0 at an edge:
  - o_Ones = 0, o_Tens = 0, o_Wrap = 0, o_Active = 0, state IDLE.
  - Previous-sample registers are forced to 1, so a button held through reset does nothing until it is released and pressed again.
  - Reset mid-operation aborts any grant or repeat immediately.
- Press event: input sampled 1 with previous sample 0.
- Arbitration in IDLE: priority Clear > Up > Down among same-cycle press events. Losers are ignored; they must be re-pressed.
- The grant is locked to the winner until that input is sampled 0.
- Exception: a Clear press preempts an Up/Down grant. Value goes to 0, and the grant moves to Clear.
- Up/Down presses during an existing grant are ignored.
- FSM states:
  - IDLE: no grant. Press event → apply step, go to DELAY (Up/Down) or CLEAR_HOLD (Clear).
  - DELAY: count REPEAT_DELAY cycles from the first step. Expiry with input still 1 → step, go to REPEAT. Input 0 → IDLE.
  - REPEAT: step every REPEAT_RATE cycles while the input is 1. Input 0 → IDLE.
  - CLEAR_HOLD: no repeat (value stays 0). Clear released → IDLE.
- Step arithmetic, in BCD and never binary:
  - Up: if value == COUNT_LIMIT → 00 with o_Wrap. Else ones+1; if ones was 9, ones = 0 and tens+1.
  - Down: if value == 00 → COUNT_LIMIT with o_Wrap. Else ones−1; if ones was 0, ones = 9 and tens−1.
- Timer: one down-counter wide enough for max(REPEAT_DELAY, REPEAT_RATE). It is reloaded on every step and cleared on leaving DELAY/REPEAT.

## Timing
- Press-to-display latency: 1 edge. With the press sampled at edge k, o_Ones/o_Tens/o_Wrap/o_Active all reflect the step after edge k.
- Repeat schedule with first step at edge k and input held:
  - First repeat step at edge k+REPEAT_DELAY.
  - Subsequent steps at k+REPEAT_DELAY+n·REPEAT_RATE.
- Release: at the edge where the granted input samples 0, state → IDLE and no step occurs that edge, even if a timer expiry coincides. o_Active falls after that edge.
- A new press is accepted at the edge after release at the earliest, since the previous-sample register must see 0.
- o_Wrap is high for exactly one cycle per wrap step, and low otherwise.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/header: FSM state encodings (IDLE, DELAY, REPEAT, CLEAR_HOLD), BCD digit constants (0, 9), and default timing parameter values for 25 MHz.
- Sub-module bcd_step: combinational, taking tens, ones, direction and limit, and returning next tens, ones and the wrap flag. It is reused for Up and Down.
- Top-level use: three debounce_module instances drive count_ctrl, and two seven_segment instances consume o_Tens and o_Ones.

## Test plan
Bench parameters: COUNT_LIMIT=12, REPEAT_DELAY=8, REPEAT_RATE=4.
- Reset with i_Up held, then release i_Rst_L → value stays 00. Release i_Up and press again → 01 one edge after the press; o_Active = 1.
- Hold i_Up from 00 for 20 cycles:
  - Value 01 at edge k, 02 at k+8, 03 at k+12, 04 at k+16, 05 at k+20.
  - Release → o_Active = 0 next edge, and no further steps.
- From 12 press i_Up → 00 with a one-cycle o_Wrap. From 00 press i_Down → 12 with o_Wrap.
- Boundaries: from 09, Up → 10 (BCD carry, tens=1, ones=0). From 10, Down → 09.
- i_Up and i_Down pressed in the same cycle from 05 → 06; i_Down is ignored until re-pressed.
- Holding i_Down at 07 through the repeat phase, press i_Clear → 00 next edge, and no further steps while Clear is held. Assert i_Rst_L=0 mid-DELAY → all outputs 0 next edge.
